// File: rtl/wm8978_i2c_pkg.sv
// Shared types and constants for the WM8978 I2C register write engine.
// The state enum, bit-phase encoding and byte geometry live here so the top and bench agree.
package wm8978_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_START = 4'd1,
        ST_ADDR  = 4'd2,
        ST_ACK1  = 4'd3,
        ST_BYTE1 = 4'd4,
        ST_ACK2  = 4'd5,
        ST_BYTE2 = 4'd6,
        ST_ACK3  = 4'd7,
        ST_STOP  = 4'd8,
        ST_DONE  = 4'd9
    } i2c_state_t;

    localparam logic [1:0] PH_DRIVE  = 2'd0;
    localparam logic [1:0] PH_RISE   = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_FALL   = 2'd3;

    localparam logic [6:0] WM8978_DEV_ADDR = 7'h1A;
    localparam int         BITS_PER_BYTE   = 8;

    function automatic logic is_ack_state(input i2c_state_t s);
        return (s == ST_ACK1) || (s == ST_ACK2) || (s == ST_ACK3);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-SCL-period tick generator: free-running modulo-DIV counter with a synchronous clear.
module i2c_qtick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || (cnt == LAST))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/wm8978_i2c_wr.sv
// Single-master I2C write engine: sends {dev+W, {reg_addr, data[8]}, data[7:0]} per command
// and reports completion plus NACK status back to the WM8978 config sequencer.
module wm8978_i2c_wr
    import wm8978_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = WM8978_DEV_ADDR,
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         I2C_FREQ   = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_exec,
    input  logic [15:0] i2c_data,
    output logic        i2c_done,
    output logic        i2c_ack,
    output logic        i2c_busy,
    output logic        scl,
    inout  wire         sda
);

    // Quarter-period length; must stay >= 2 so the sampled ACK settles through the synchroniser.
    localparam int DIV = CLK_FREQ / (I2C_FREQ * 4);

    i2c_state_t  state, state_n;
    logic [1:0]  phase, phase_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [15:0] cmd;
    logic        ack_n;
    logic        load;
    logic        clr;
    logic        tick;
    logic        sda_meta, sda_sync;
    logic        sda_low, sda_low_n;
    logic        scl_n;
    logic [7:0]  tx_byte;

    i2c_qtick_gen #(.DIV(DIV)) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda;
            sda_sync <= sda_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= PH_DRIVE;
            bit_cnt <= 3'(BITS_PER_BYTE - 1);
            cmd     <= '0;
            i2c_ack <= 1'b0;
            scl     <= 1'b1;
            sda_low <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_cnt_n;
            i2c_ack <= ack_n;
            scl     <= scl_n;
            sda_low <= sda_low_n;
            if (load)
                cmd <= i2c_data;
        end
    end

    // Sequencing: every transition outside IDLE/DONE waits for a quarter tick.
    // i2c_ack doubles as the NACK flag; it is only ever set just before heading to STOP.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        ack_n     = i2c_ack;
        load      = 1'b0;
        clr       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i2c_exec) begin
                    state_n   = ST_START;
                    phase_n   = PH_DRIVE;
                    bit_cnt_n = 3'(BITS_PER_BYTE - 1);
                    ack_n     = 1'b0;
                    load      = 1'b1;
                    clr       = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: begin
                if (tick) begin
                    phase_n = phase + 2'd1;
                    if (is_ack_state(state) && (phase == PH_SAMPLE) && sda_sync)
                        ack_n = 1'b1;
                    if (phase == PH_FALL) begin
                        bit_cnt_n = 3'(BITS_PER_BYTE - 1);
                        case (state)
                            ST_START: state_n = ST_ADDR;
                            ST_ADDR: begin
                                bit_cnt_n = bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) state_n = ST_ACK1;
                            end
                            ST_BYTE1: begin
                                bit_cnt_n = bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) state_n = ST_ACK2;
                            end
                            ST_BYTE2: begin
                                bit_cnt_n = bit_cnt - 3'd1;
                                if (bit_cnt == 3'd0) state_n = ST_ACK3;
                            end
                            ST_ACK1: state_n = i2c_ack ? ST_STOP : ST_BYTE1;
                            ST_ACK2: state_n = i2c_ack ? ST_STOP : ST_BYTE2;
                            ST_ACK3: state_n = ST_STOP;
                            ST_STOP: state_n = ST_DONE;
                            default: state_n = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus levels are computed for the upcoming state/phase and registered, keeping scl glitch-free.
    always_comb begin
        tx_byte   = 8'hFF;
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        case (state_n)
            ST_ADDR:  tx_byte = {SLAVE_ADDR, 1'b0};
            ST_BYTE1: tx_byte = cmd[15:8];
            ST_BYTE2: tx_byte = cmd[7:0];
            default:  tx_byte = 8'hFF;
        endcase
        case (state_n)
            ST_START: begin
                scl_n     = (phase_n != PH_FALL);
                sda_low_n = (phase_n == PH_SAMPLE) || (phase_n == PH_FALL);
            end
            ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                scl_n     = (phase_n == PH_RISE) || (phase_n == PH_SAMPLE);
                sda_low_n = ~tx_byte[bit_cnt_n];
            end
            ST_ACK1, ST_ACK2, ST_ACK3: begin
                scl_n = (phase_n == PH_RISE) || (phase_n == PH_SAMPLE);
            end
            ST_STOP: begin
                scl_n     = (phase_n != PH_DRIVE);
                sda_low_n = (phase_n == PH_DRIVE) || (phase_n == PH_RISE);
            end
            default: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase
    end

    assign sda      = sda_low ? 1'b0 : 1'bz;
    assign i2c_done = (state == ST_DONE);
    assign i2c_busy = (state != ST_IDLE) || i2c_exec;

endmodule

// File: tb/tb_wm8978_i2c_wr.sv
// Bench for wm8978_i2c_wr: an I2C bus decoder plus ACK/NACK slave, checked against
// byte lists and tick counts derived from the command and the NACK position.
module tb_wm8978_i2c_wr;

    localparam int DIV       = 50_000_000 / (250_000 * 4);
    localparam int NO_NACK   = 3;
    localparam int WAIT_MAX  = 7000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2c_exec = 1'b0;
    logic [15:0] i2c_data = '0;
    logic        i2c_done, i2c_ack, i2c_busy, scl;
    wire         sda;

    int checks   = 0;
    int failures = 0;

    wm8978_i2c_wr dut (
        .clk      (clk),
        .rst      (rst),
        .i2c_exec (i2c_exec),
        .i2c_data (i2c_data),
        .i2c_done (i2c_done),
        .i2c_ack  (i2c_ack),
        .i2c_busy (i2c_busy),
        .scl      (scl),
        .sda      (sda)
    );

    pullup pu_sda (sda);

    always #10 clk = ~clk;

    // Bus decoder and slave: frames bytes on scl rising edges and answers each 9th bit.
    int         nack_byte = NO_NACK;
    logic       slave_low = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         mon_bit = 0, frame_byte = 0;
    logic [7:0] acc = '0;
    logic [7:0] rx_q[$];
    int         start_cnt = 0, stop_cnt = 0;

    assign sda = slave_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        if (rst) begin
            mon_bit   = 0;
            slave_low = 1'b0;
        end else if (scl && prev_scl && prev_sda && !sda) begin
            start_cnt++;
            mon_bit    = 0;
            frame_byte = 0;
        end else if (scl && prev_scl && !prev_sda && sda) begin
            stop_cnt++;
            mon_bit   = 0;
            slave_low = 1'b0;
        end else if (scl && !prev_scl) begin
            if (mon_bit < 8) begin
                acc = {acc[6:0], sda};
                mon_bit++;
                if (mon_bit == 8) rx_q.push_back(acc);
            end else begin
                mon_bit = 9;
            end
        end else if (!scl && prev_scl) begin
            if (mon_bit == 8) begin
                slave_low = (frame_byte != nack_byte);
            end else if (mon_bit == 9) begin
                slave_low = 1'b0;
                mon_bit   = 0;
                frame_byte++;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    initial begin
        #(20 * 90_000);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int base_rx, base_start, base_stop;

    task automatic applyStimulus(input logic [15:0] data);
        @(negedge clk);
        base_rx    = rx_q.size();
        base_start = start_cnt;
        base_stop  = stop_cnt;
        i2c_data   = data;
        i2c_exec   = 1'b1;
        #1;
        checkOutput("busy_at_accept", {31'b0, i2c_busy}, 32'd1);
    endtask

    // Expected bytes and tick count come straight from the frame layout: 9 bits per byte,
    // 4 ticks per bit, framed by a 4-tick START and a 4-tick STOP.
    task automatic waitDone(input logic [15:0] data, input int nack_at, input int mid_at,
                            input bit done_pulse, input string name);
        int         cycles, busy_drop, nbytes, idx;
        logic [7:0] exp_b[3];
        logic [7:0] obs;
        logic [6:0] dev;
        dev      = 7'h1A;
        exp_b[0] = {dev, 1'b0};
        exp_b[1] = data[15:8];
        exp_b[2] = data[7:0];
        nbytes   = (nack_at < NO_NACK) ? nack_at + 1 : 3;
        cycles    = 0;
        busy_drop = 0;
        @(negedge clk);
        cycles   = 1;
        i2c_exec = (cycles == mid_at);
        while (!i2c_done && cycles < WAIT_MAX) begin
            if (!i2c_busy) busy_drop++;
            @(negedge clk);
            cycles++;
            i2c_exec = (cycles == mid_at);
        end
        if (done_pulse) i2c_exec = 1'b1;
        checkOutput({name, "_latency"}, cycles, (8 + 36 * nbytes) * DIV + 1);
        checkOutput({name, "_busy_held"}, busy_drop, 0);
        checkOutput({name, "_busy_at_done"}, {31'b0, i2c_busy}, 32'd1);
        checkOutput({name, "_ack"}, {31'b0, i2c_ack}, (nack_at < NO_NACK) ? 32'd1 : 32'd0);
        checkOutput({name, "_nbytes"}, rx_q.size() - base_rx, nbytes);
        for (int i = 0; i < nbytes; i++) begin
            idx = base_rx + i;
            obs = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
            checkOutput($sformatf("%s_byte%0d", name, i), {24'b0, obs}, {24'b0, exp_b[i]});
        end
        checkOutput({name, "_starts"}, start_cnt - base_start, 1);
        checkOutput({name, "_stops"}, stop_cnt - base_stop, 1);
    endtask

    task automatic runTxn(input logic [15:0] data, input int nack_at, input string name);
        nack_byte = nack_at;
        applyStimulus(data);
        waitDone(data, nack_at, 0, 1'b0, name);
    endtask

    initial begin
        int bad;
        logic [15:0] rdata;
        int rnack;

        repeat (3) @(negedge clk);
        checkOutput("reset_scl", {31'b0, scl}, 32'd1);
        checkOutput("reset_sda", {31'b0, sda}, 32'd1);
        checkOutput("reset_busy", {31'b0, i2c_busy}, 32'd0);
        checkOutput("reset_done", {31'b0, i2c_done}, 32'd0);
        checkOutput("reset_ack", {31'b0, i2c_ack}, 32'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (scl !== 1'b1 || sda !== 1'b1 || i2c_busy !== 1'b0 || i2c_done !== 1'b0) bad++;
        end
        checkOutput("idle_1000", bad, 0);
        checkOutput("idle_starts", start_cnt, 0);

        runTxn(16'h0201, NO_NACK, "reg1");
        runTxn({7'd2, 9'h180}, NO_NACK, "reg2");
        runTxn(16'h1234, 0, "nack_addr");

        @(negedge clk);
        checkOutput("ack_holds", {31'b0, i2c_ack}, 32'd1);

        // Pulse during the transfer and on the i2c_done cycle; neither may start a frame.
        nack_byte = NO_NACK;
        applyStimulus(16'hA5C3);
        waitDone(16'hA5C3, NO_NACK, 1000, 1'b1, "ignore");
        @(negedge clk);
        i2c_exec = 1'b0;
        #1;
        checkOutput("done_cycle_exec_ignored", {31'b0, i2c_busy}, 32'd0);
        base_start = start_cnt;
        repeat (300) @(negedge clk);
        checkOutput("no_extra_start", start_cnt - base_start, 0);

        runTxn(16'h3E07, NO_NACK, "b2b_first");
        runTxn(16'h0C99, NO_NACK, "b2b_second");

        // Reset during BYTE1 must drop the bus immediately without a STOP or done.
        nack_byte = NO_NACK;
        applyStimulus(16'h7F55);
        @(negedge clk);
        i2c_exec = 1'b0;
        repeat (2400) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_scl", {31'b0, scl}, 32'd1);
        checkOutput("rst_sda", {31'b0, sda}, 32'd1);
        checkOutput("rst_busy", {31'b0, i2c_busy}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i2c_done !== 1'b0 || scl !== 1'b1 || i2c_busy !== 1'b0) bad++;
        end
        checkOutput("rst_quiet", bad, 0);
        runTxn(16'h4D2A, NO_NACK, "after_rst");

        for (int t = 0; t < 3; t++) begin
            rdata = 16'($urandom);
            rnack = int'($urandom_range(0, 3));
            runTxn(rdata, rnack, $sformatf("rand%0d", t));
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
